// File: rtl/maple_seq_pkg.sv
// Maple Bus transaction sequencer: shared types.
//   seq_state_e  : one-hot sequencer states
//   seq_status_e : completion codes reported on status
package maple_seq_pkg;

  typedef enum logic [5:0] {
    S_IDLE    = 6'b000001,
    S_TX      = 6'b000010,
    S_TURN    = 6'b000100,
    S_RX_WAIT = 6'b001000,
    S_RX_ACT  = 6'b010000,
    S_DONE    = 6'b100000
  } seq_state_e;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_TIMEOUT  = 2'd1,
    ST_RX_ERROR = 2'd2,
    ST_ABORTED  = 2'd3
  } seq_status_e;

endpackage

// File: rtl/maple_seq_timer.sv
// Loadable saturating down-counter shared by the turnaround and the
// response-timeout phases of the sequencer.
// Ports:
//   aclk, areset : clock, asynchronous active-high reset (count -> 0)
//   load         : load load_value this cycle (wins over decrement)
//   load_value   : value to load
//   zero         : count is 0 (counter holds at 0, never wraps)
module maple_seq_timer #(
  parameter int CNT_WIDTH = 20
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  output logic                 zero
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/maple_txn_sequencer.sv
// Maple Bus transaction sequencer. Shares the SDCKA/SDCKB pin pair between
// transmitter and receiver: drives the command, releases the bus for a
// turnaround gap, then listens for a response frame under a timeout.
// Optional build macro: MAPLE_SEQ_RETRY_EN -- a TIMEOUT or RX_ERROR on the
// first attempt re-runs the transaction once; adds output 'retried'.
// Ports:
//   aclk, areset     : clock, asynchronous active-high reset
//   cmd_valid/ready  : command handshake (ready == idle)
//   cmd_expect_resp  : sampled with the command, 1 = response expected
//   abort            : level, ends any active transaction as ABORTED
//   tx_enable/tx_done: transmitter enable / end-of-frame pulse
//   rx_enable        : receiver enable
//   rx_receiving     : receiver saw a start pattern
//   rx_last/rx_error : last accepted beat / frame error pulse
//   bus_drive_en     : pin output-enable
//   busy             : transaction in progress (incl. the DONE cycle)
//   status/valid     : completion code and its one-cycle update pulse
//   retried          : (MAPLE_SEQ_RETRY_EN only) status came from a retry
module maple_txn_sequencer
  import maple_seq_pkg::*;
#(
  parameter int TURNAROUND_CYCLES   = 4,
  parameter int RESP_TIMEOUT_CYCLES = 100000,
  parameter int CNT_WIDTH           = 20
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_expect_resp,
  input  logic       abort,
  output logic       tx_enable,
  input  logic       tx_done,
  output logic       rx_enable,
  input  logic       rx_receiving,
  input  logic       rx_last,
  input  logic       rx_error,
  output logic       bus_drive_en,
  output logic       busy,
  output logic [1:0] status,
  output logic       status_valid
`ifdef MAPLE_SEQ_RETRY_EN
  ,
  output logic       retried
`endif
);

  localparam logic [CNT_WIDTH-1:0] TURN_LOAD = CNT_WIDTH'(TURNAROUND_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RESP_LOAD = CNT_WIDTH'(RESP_TIMEOUT_CYCLES - 1);

  seq_state_e           state, state_nxt;
  seq_status_e          done_status;
  logic                 expect_resp;
  logic                 tmr_load;
  logic [CNT_WIDTH-1:0] tmr_value;
  logic                 tmr_zero;
`ifdef MAPLE_SEQ_RETRY_EN
  logic                 second_attempt;
  logic                 retry_take;
`endif

  maple_seq_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
    .aclk       (aclk),
    .areset     (areset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .zero       (tmr_zero)
  );

  assign cmd_ready = (state == S_IDLE);

  // Next-state logic. abort outranks every other event in the active states.
  always_comb begin
    state_nxt   = state;
    done_status = ST_OK;
    tmr_load    = 1'b0;
    tmr_value   = TURN_LOAD;
    case (state)
      S_IDLE: begin
        if (cmd_valid) state_nxt = S_TX;
      end
      S_TX: begin
        if (abort) begin
          state_nxt   = S_DONE;
          done_status = ST_ABORTED;
        end else if (tx_done) begin
          if (expect_resp) begin
            state_nxt = S_TURN;
            tmr_load  = 1'b1;
            tmr_value = TURN_LOAD;
          end else begin
            state_nxt   = S_DONE;
            done_status = ST_OK;
          end
        end
      end
      S_TURN: begin
        if (abort) begin
          state_nxt   = S_DONE;
          done_status = ST_ABORTED;
        end else if (tmr_zero) begin
          state_nxt = S_RX_WAIT;
          tmr_load  = 1'b1;
          tmr_value = RESP_LOAD;
        end
      end
      S_RX_WAIT: begin
        // A start pattern seen on the last wait cycle still counts.
        if (abort) begin
          state_nxt   = S_DONE;
          done_status = ST_ABORTED;
        end else if (rx_receiving) begin
          state_nxt = S_RX_ACT;
          tmr_load  = 1'b1;
          tmr_value = RESP_LOAD;
        end else if (tmr_zero) begin
          state_nxt   = S_DONE;
          done_status = ST_TIMEOUT;
        end
      end
      S_RX_ACT: begin
        if (abort) begin
          state_nxt   = S_DONE;
          done_status = ST_ABORTED;
        end else if (rx_error) begin
          state_nxt   = S_DONE;
          done_status = ST_RX_ERROR;
        end else if (rx_last) begin
          state_nxt   = S_DONE;
          done_status = ST_OK;
        end else if (tmr_zero) begin
          state_nxt   = S_DONE;
          done_status = ST_TIMEOUT;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
`ifdef MAPLE_SEQ_RETRY_EN
    // A first-attempt failure goes back to TX instead of reporting.
    retry_take = (state_nxt == S_DONE) && !second_attempt &&
                 ((done_status == ST_TIMEOUT) || (done_status == ST_RX_ERROR));
    if (retry_take) state_nxt = S_TX;
`endif
  end

  // State and registered outputs, all decoded from the next state so they
  // line up with the state they describe.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state        <= S_IDLE;
      tx_enable    <= 1'b0;
      bus_drive_en <= 1'b0;
      rx_enable    <= 1'b0;
      busy         <= 1'b0;
      status_valid <= 1'b0;
      status       <= ST_OK;
    end else begin
      state        <= state_nxt;
      tx_enable    <= (state_nxt == S_TX);
      bus_drive_en <= (state_nxt == S_TX);
      rx_enable    <= (state_nxt == S_RX_WAIT) || (state_nxt == S_RX_ACT);
      busy         <= (state_nxt != S_IDLE);
      status_valid <= (state_nxt == S_DONE);
      if (state_nxt == S_DONE) status <= done_status;
    end
  end

  // Command attribute, only meaningful while a transaction is active.
  always_ff @(posedge aclk) begin
    if (cmd_ready && cmd_valid) expect_resp <= cmd_expect_resp;
  end

`ifdef MAPLE_SEQ_RETRY_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      second_attempt <= 1'b0;
      retried        <= 1'b0;
    end else begin
      if (cmd_ready && cmd_valid) second_attempt <= 1'b0;
      else if (retry_take)        second_attempt <= 1'b1;
      if (state_nxt == S_DONE) retried <= second_attempt;
    end
  end
`endif

endmodule

// File: doc/maple_txn_sequencer.md
Name: maple_txn_sequencer

Overview:
Transaction sequencer for the Maple Bus port. It shares the single SDCKA/SDCKB pin pair between the transmitter and the receiver. For each command it enables the transmitter and owns the pin output-enable. It then releases the bus, waits a turnaround gap, enables the receiver, and watches for a response frame under a timeout. It sits between the host command/status registers and the tx/rx stream blocks.

Parameters:
TURNAROUND_CYCLES, 4, aclk cycles with pins tri-stated between end of TX and rx_enable assertion (≥1).
RESP_TIMEOUT_CYCLES, 100000, max aclk cycles waiting for a response start, and max cycles of a response frame (≥2).
CNT_WIDTH, 20, counter width; must hold max(TURNAROUND_CYCLES, RESP_TIMEOUT_CYCLES).

Ports:
aclk  in  1  clock
areset  in  1  reset, asynchronous, active-high
cmd_valid  in  1  start-transaction request
cmd_ready  out  1  sequencer idle, command accepted when cmd_valid&&cmd_ready
cmd_expect_resp  in  1  sampled with command; 1 = response frame expected
abort  in  1  level; terminates any active transaction
tx_enable  out  1  transmitter enable
tx_done  in  1  one-cycle pulse, transmitter finished end pattern
rx_enable  out  1  receiver enable
rx_receiving  in  1  receiver has detected a start pattern
rx_last  in  1  accepted beat with TLAST (TVALID&TREADY&TLAST)
rx_error  in  1  receiver frame error pulse
bus_drive_en  out  1  pin output-enable for SDCKA/SDCKB
busy  out  1  transaction in progress
status  out  2  0 OK, 1 TIMEOUT, 2 RX_ERROR, 3 ABORTED
status_valid  out  1  one-cycle pulse when status updates

Behaviour:
- Reset, asynchronous on areset: state IDLE; tx_enable, rx_enable, bus_drive_en, busy, status_valid = 0; status = 0; counter = 0; cmd_ready = 1.
- cmd_ready = (state == IDLE). All other outputs are registered.
- IDLE: on cmd_valid&&cmd_ready, latch cmd_expect_resp and go to TX. tx_enable and bus_drive_en are 1 from the next cycle. tx_done, rx_* and abort are ignored in IDLE.
- TX: tx_enable = bus_drive_en = 1.
  - On tx_done with expect_resp=0: go to DONE with status OK.
  - On tx_done with expect_resp=1: go to TURN; load counter = TURNAROUND_CYCLES-1.
  - No timeout applies in TX.
- TURN: all enables 0 (bus released). Counter decrements each cycle. At 0, go to RX_WAIT and load counter = RESP_TIMEOUT_CYCLES-1. rx_enable rises exactly TURNAROUND_CYCLES+1 cycles after tx_done.
- RX_WAIT: rx_enable = 1.
  - rx_receiving=1: go to RX_ACT and reload the counter.
  - Otherwise counter reaches 0: go to DONE with status TIMEOUT.
- RX_ACT: rx_enable = 1.
  - rx_error: go to DONE, RX_ERROR.
  - rx_last: go to DONE, OK.
  - Counter reaches 0: go to DONE, TIMEOUT.
  - Priority: error > last > timeout when simultaneous.
- DONE: one cycle. All enables 0. status_valid = 1; status is updated the same cycle and held until the next DONE. Next state IDLE. cmd_ready therefore returns one cycle after DONE.
- abort=1 in TX/TURN/RX_WAIT/RX_ACT: go to DONE with status ABORTED. abort beats every other event in the same cycle. Enables drop on the next edge.
- bus_drive_en and rx_enable are never 1 in the same cycle, and bus_drive_en is 0 for ≥TURNAROUND_CYCLES cycles before rx_enable=1.
- busy = 1 in all states except IDLE, including DONE.
- Counter: unsigned CNT_WIDTH, saturating at 0, no wrap.

Optional Feature:
MAPLE_SEQ_RETRY_EN
- Defined: on TIMEOUT or RX_ERROR of a first attempt, the sequencer does not enter DONE. It re-enters TX once with the same expect_resp; a second failure goes to DONE with that status. ABORTED is never retried. Adds output retried (1 bit), which is valid with status_valid and reset to 0.
- Undefined: no retry, no retried port; any failure goes straight to DONE.

Decomposition:
- Package maple_seq_pkg:
  - state encoding: one-hot IDLE/TX/TURN/RX_WAIT/RX_ACT/DONE;
  - status codes: ST_OK, ST_TIMEOUT, ST_RX_ERROR, ST_ABORTED.
- Sub-module maple_seq_timer: loadable saturating down-counter (load, load_value, zero flag). It is shared by the turnaround and timeout phases.

Test Plan (TURNAROUND_CYCLES=4, RESP_TIMEOUT_CYCLES=16):
- cmd_valid with expect_resp=0, tx_done 10 cycles later -> status_valid 1 cycle after tx_done, status=0, rx_enable never 1, cmd_ready high 2 cycles after tx_done.
- expect_resp=1, tx_done at t, rx_receiving at t+8, rx_last at t+20 -> bus_drive_en falls at t+1, rx_enable rises at t+5, status=0 pulse at t+21.
- expect_resp=1, no rx_receiving -> status=1 (TIMEOUT) pulse 16 cycles after rx_enable rose; rx_enable drops with it.
- In RX_ACT, rx_error and rx_last in same cycle -> status=2; abort asserted in TURN -> status=3 next cycle, no rx_enable.
- areset pulse mid-RX_ACT (asynchronous, between edges) -> all enables 0 immediately, cmd_ready=1, status=0, and no status_valid.
- With MAPLE_SEQ_RETRY_EN: first timeout -> tx_enable reasserts; second timeout -> status=1, retried=1. Without the macro -> single timeout terminates.
